// File: rtl/vape_exec_ctrl_if.sv
// CPU and DMA bus view seen by the VAPE execution controller.
// The CPU or bench drives it as master; the controller samples it as slave.
interface vape_exec_ctrl_if;
    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        dma_en;
    logic [15:0] dma_addr;

    modport master (
        output data_en,
        output data_wr,
        output data_addr,
        output data_wdata,
        output dma_en,
        output dma_addr
    );

    modport slave (
        input data_en,
        input data_wr,
        input data_addr,
        input data_wdata,
        input dma_en,
        input dma_addr
    );
endinterface

// File: rtl/vape_exec_ctrl.sv
// VAPE sequencing controller: holds the ER/OR bounds in META registers,
// tracks executable-region runs and raises EXEC on a clean run.
module vape_exec_ctrl #(
    parameter logic [15:0] META_BASE = 16'hFF00,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    vape_exec_ctrl_if.slave  bus,
    input  logic [15:0]      pc_i,
    input  logic             monitor_ok_i,
    output logic [15:0]      er_min_o,
    output logic [15:0]      er_max_o,
    output logic [15:0]      or_min_o,
    output logic [15:0]      or_max_o,
    output logic             cfg_valid_o,
    output logic             exec_o,
    output logic [2:0]       state_o,
    output logic [7:0]       abort_cnt_o,
    output logic [CNT_W-1:0] run_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      er_min_q, er_max_q, or_min_q, or_max_q;
    logic             cfg_valid_q, exec_q, bounds_chg_q;
    logic [7:0]       abort_cnt_q;
    logic [CNT_W-1:0] run_q;

    logic cfg_hit, cfg_acc, cfg_ok, viol;
    logic unused_dma;

    assign unused_dma = ^{bus.dma_en, bus.dma_addr};

    assign cfg_hit = bus.data_en && bus.data_wr &&
                     (bus.data_addr >= META_BASE) &&
                     (bus.data_addr <= META_BASE + 16'd7);
    assign cfg_acc = cfg_hit && (state_q != S_RUN);
    assign viol    = !monitor_ok_i;

    assign cfg_ok = (er_min_q <= er_max_q) && !er_min_q[0] &&
                    (or_min_q <= or_max_q) &&
                    ((or_max_q < er_min_q) || (or_min_q > er_max_q));

    // cfg_valid lags a bound write by a cycle, so arming waits one
    // extra cycle after any write to avoid acting on a stale verdict.
    always_comb begin
        state_d = state_q;
        if (viol) begin
            if (state_q == S_RUN || state_q == S_DONE)
                state_d = S_ABORT;
        end else if (cfg_acc) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:
                    if (cfg_valid_q && !bounds_chg_q) state_d = S_ARMED;
                S_ARMED:
                    if (!cfg_valid_q)            state_d = S_IDLE;
                    else if (pc_i == er_min_q)   state_d = S_RUN;
                S_RUN:
                    if (pc_i == er_max_q)        state_d = S_DONE;
                S_DONE, S_ABORT:
                    if (pc_i == er_min_q)        state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            er_min_q     <= '0;
            er_max_q     <= '0;
            or_min_q     <= '0;
            or_max_q     <= '0;
            cfg_valid_q  <= 1'b0;
            bounds_chg_q <= 1'b0;
            exec_q       <= 1'b0;
            abort_cnt_q  <= '0;
            run_q        <= '0;
        end else begin
            state_q      <= state_d;
            exec_q       <= (state_d == S_DONE);
            cfg_valid_q  <= cfg_ok;
            bounds_chg_q <= cfg_acc;
            if (cfg_acc) begin
                unique case (bus.data_addr[2:1])
                    2'd0: er_min_q <= bus.data_wdata;
                    2'd1: er_max_q <= bus.data_wdata;
                    2'd2: or_min_q <= bus.data_wdata;
                    2'd3: or_max_q <= bus.data_wdata;
                    default: ;
                endcase
            end
            if (state_d == S_ABORT && state_q != S_ABORT &&
                abort_cnt_q != 8'hFF)
                abort_cnt_q <= abort_cnt_q + 8'd1;
            if (state_d == S_RUN) begin
                if (state_q != S_RUN)
                    run_q <= CNT_W'(1);
                else if (run_q != '1)
                    run_q <= run_q + CNT_W'(1);
            end
        end
    end

    assign er_min_o     = er_min_q;
    assign er_max_o     = er_max_q;
    assign or_min_o     = or_min_q;
    assign or_max_o     = or_max_q;
    assign cfg_valid_o  = cfg_valid_q;
    assign exec_o       = exec_q;
    assign state_o      = state_q;
    assign abort_cnt_o  = abort_cnt_q;
    assign run_cycles_o = run_q;

endmodule

// File: doc/vape_exec_ctrl.md
Name: vape_exec_ctrl

Overview:
- Sequencing controller for the VAPE proof-of-execution monitor set.
- Holds the ER/OR bounds in memory-mapped META registers and drives them to the monitors.
- Tracks executable-region execution through a state machine and generates the EXEC flag from the monitors' combined verdict (monitor_ok).
- Sits between the openMSP430 data bus and the VAPE monitor instances.

Parameters:
- META_BASE, 16'hFF00, base of config words: ER_min +0, ER_max +2, OR_min +4, OR_max +6.
- CNT_W, 16, width of the run-cycle counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pc  input  16  current CPU program counter
- data_en  input  1  CPU data access strobe
- data_wr  input  1  CPU write qualifier
- data_addr  input  16  CPU data address
- data_wdata  input  16  CPU write data
- dma_en  input  1  DMA access strobe
- dma_addr  input  16  DMA address
- monitor_ok  input  1  AND of all VAPE sub-monitor outputs; 0 = violation
- ER_min, ER_max, OR_min, OR_max  output  16 each  registered bounds to monitors
- cfg_valid  output  1  registered bounds-consistency flag
- exec  output  1  registered EXEC flag
- state  output  3  FSM state encoding
- abort_cnt  output  8  saturating count of ABORT entries
- run_cycles  output  CNT_W  cycles spent in the last/current RUNNING interval

Behaviour:
- Reset: all bound registers 0, cfg_valid 0, exec 0, state IDLE, abort_cnt 0, run_cycles 0. Reset mid-run has the same effect and drops exec in the cycle after reset is sampled.
- Config write condition: data_en & data_wr & data_addr in [META_BASE, META_BASE+7].
  - The word index is taken from data_addr[2:1]; data_addr[0] is ignored.
  - The write is accepted only in IDLE, ARMED, DONE or ABORT. In RUNNING it is ignored.
  - DMA never writes config; dma_en and dma_addr only matter through monitor_ok.
- cfg_valid, registered one cycle after any bound change, is 1 iff all of:
  - ER_min <= ER_max
  - ER_min[0] == 0
  - OR_min <= OR_max
  - the ranges do not overlap: OR_max < ER_min or OR_min > ER_max.
  At reset the bounds are all-zero, so ER and OR overlap and cfg_valid = 0.
- State encodings: IDLE=0, ARMED=1, RUNNING=2, DONE=3, ABORT=4.
- Transition priority: reset > violation (monitor_ok=0) > accepted config write > pc match.
- IDLE:
  - cfg_valid=1 -> ARMED.
- ARMED:
  - pc==ER_min & monitor_ok -> RUNNING.
  - cfg_valid=0 -> IDLE.
- RUNNING:
  - monitor_ok=0 -> ABORT.
  - pc==ER_max & monitor_ok -> DONE.
  - Otherwise stay.
- DONE:
  - exec=1.
  - monitor_ok=0 -> ABORT.
  - Accepted config write -> IDLE.
  - pc==ER_min -> RUNNING.
- ABORT:
  - exec=0.
  - Accepted config write -> IDLE.
  - pc==ER_min & monitor_ok -> RUNNING.
- exec is registered and is 1 exactly while in DONE.
  - It rises the cycle after the ER_max match.
  - It falls the cycle after a violation, re-entry to RUNNING, or an accepted config write.
- Violation while in IDLE or ARMED: state unchanged, abort_cnt unchanged.
- abort_cnt: +1 on every transition into ABORT, saturating at 8'hFF.
- run_cycles:
  - Loaded with 1 on entry to RUNNING.
  - +1 each cycle in RUNNING, saturating at all-ones.
  - Held outside RUNNING.
- Single-instruction ER (ER_min==ER_max): the ARMED pc match goes to RUNNING. The next cycle with pc==ER_max & monitor_ok goes to DONE.
- Simultaneous violation and pc==ER_max in RUNNING: ABORT wins and exec stays 0.
- A config write in the same cycle as pc==ER_min in DONE or ABORT: the write wins and state goes to IDLE.

Test Plan:
1. Write ER_min=E000, ER_max=E0FE, OR_min=0200, OR_max=021F.
   -> cfg_valid=1 one cycle after the last write; state IDLE->ARMED.
   Then pc=E000 -> RUNNING; pc=E0FE with monitor_ok=1 -> state DONE, exec=1 next cycle, run_cycles = elapsed cycles.
2. While RUNNING, drop monitor_ok for 1 cycle.
   -> state ABORT, exec=0, abort_cnt=1.
   Then a write to META_BASE+0 is accepted and state goes to IDLE.
3. Write to META_BASE+2 during RUNNING.
   -> ER_max unchanged, state stays RUNNING.
4. Overlapping config: ER E000-E0FE, OR E080-E090.
   -> cfg_valid=0, state stays IDLE.
   ER_min=E001 -> cfg_valid=0.
5. From DONE, pc=E000.
   -> exec falls next cycle, state RUNNING, run_cycles=1.
   Assert reset mid-RUNNING -> all outputs 0 and state IDLE next cycle.
6. Force 300 aborts via repeated RUNNING entry plus monitor_ok=0.
   -> abort_cnt saturates at 8'hFF.
   A same-cycle violation and ER_max match -> ABORT, exec stays 0.
